// File: rtl/dmd_rd_pkg.sv
// Shared definitions for the DMD data-memory read controller:
// state encoding, abort fill pattern and the default wait timeout.
package dmd_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_EXTW   = 2'd2,
        ST_RECOV  = 2'd3
    } rd_state_e;

    localparam int TO_CYC_DEF = 255;

    // Wide all-ones pattern; the controller slices it to its data width.
    localparam int               ABORT_MAX_DW = 64;
    localparam logic [ABORT_MAX_DW-1:0] ABORT_FILL = '1;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dmd_rd_ctrl_sync.sv
// Two-flop synchronizer for an asynchronous level input. It is clock-enable
// independent so the synchronized value stays current while the core is stalled.
module rd_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/dmd_rd_ctrl.sv
// Read-side controller for the 16-bit DMD data-memory bus: address/strobe
// generation, programmed and external wait states, data capture, done/error pulse.
module dmd_rd_ctrl
    import dmd_rd_pkg::*;
#(
    parameter int AW     = 14,
    parameter int DW     = 16,
    parameter int WSW    = 3,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CKenb,
    input  logic          RD_REQ,
    input  logic [AW-1:0] RD_ADDR,
    input  logic [WSW-1:0] WAIT_CFG,
    input  logic          EXT_WAIT,
    input  logic [DW-1:0] DMD_IN,
    output logic [AW-1:0] MA_OUT,
    output logic          RD_N,
    output logic [DW-1:0] RD_DATA,
    output logic          RD_DONE,
    output logic          RD_ERR,
    output logic          BUSY,
    output logic [1:0]    dbg_state_o
);

    localparam int TW = cnt_width(TO_CYC);

    // Request/done handshake: RD_REQ is a one-shot accepted only while BUSY=0
    // and CKenb=0; it is never queued. Each accepted request yields exactly one
    // RD_DONE pulse with RD_DATA valid; RD_ERR qualifies that pulse as an abort.
    rd_state_e      state_q;
    logic [AW-1:0]  ma_q;
    logic           rd_n_q;
    logic [DW-1:0]  data_q;
    logic           done_q;
    logic           err_q;
    logic [WSW-1:0] wcnt_q;
    logic [TW-1:0]  tcnt_q;
    logic           ew_s;

    rd_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d_i (EXT_WAIT),
        .q_o (ew_s)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ma_q    <= '0;
            rd_n_q  <= 1'b1;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
        end else if (!CKenb) begin
            case (state_q)
                ST_IDLE: begin
                    if (RD_REQ) begin
                        ma_q    <= RD_ADDR;
                        rd_n_q  <= 1'b0;
                        wcnt_q  <= WAIT_CFG;
                        tcnt_q  <= '0;
                        state_q <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    // External wait is only honoured once programmed waits are spent.
                    if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - WSW'(1);
                    end else if (ew_s) begin
                        state_q <= ST_EXTW;
                    end else begin
                        data_q  <= DMD_IN;
                        rd_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_RECOV;
                    end
                end
                ST_EXTW: begin
                    tcnt_q <= tcnt_q + TW'(1);
                    if (!ew_s) begin
                        data_q  <= DMD_IN;
                        rd_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_RECOV;
                    end else if (tcnt_q == TW'(TO_CYC - 1)) begin
                        data_q  <= ABORT_FILL[DW-1:0];
                        rd_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= ST_RECOV;
                    end
                end
                ST_RECOV: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign MA_OUT      = ma_q;
    assign RD_N        = rd_n_q;
    assign RD_DATA     = data_q;
    assign RD_DONE     = done_q;
    assign RD_ERR      = err_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule
